// File: rtl/tea_block_packer_if.sv
// Byte-in / cipher-core / block-out signal bundle for tea_block_packer.
// master is the packer's view; slave is the host, core and consumer side.
interface tea_block_packer_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                   iByteValid;
    logic [7:0]             iByte;
    logic                   oByteReady;
    logic [WORD_SIZE-1:0]   oV0;
    logic [WORD_SIZE-1:0]   oV1;
    logic                   oStart;
    logic                   iDone;
    logic [WORD_SIZE-1:0]   iC0;
    logic [WORD_SIZE-1:0]   iC1;
    logic [2*WORD_SIZE-1:0] oBlock;
    logic                   oBlockValid;
    logic                   iBlockReady;
    logic                   oError;

    modport master (
        input  iByteValid, iByte, iDone, iC0, iC1, iBlockReady,
        output oByteReady, oV0, oV1, oStart, oBlock, oBlockValid, oError
    );

    modport slave (
        output iByteValid, iByte, iDone, iC0, iC1, iBlockReady,
        input  oByteReady, oV0, oV1, oStart, oBlock, oBlockValid, oError
    );
endinterface

// File: rtl/tea_block_packer.sv
// Packs a big-endian byte stream into one TEA plaintext block, runs the core, presents {C0,C1}.
// Optional RUN watchdog with sticky oError: define TEA_PACKER_TIMEOUT_EN.
module tea_block_packer #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic               clk,
    input  logic               rst,
    tea_block_packer_if.master bus
);
    localparam int unsigned BYTES = 2 * WORD_SIZE / 8;
    localparam int unsigned CW    = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] OUT     = 2'd3;

    logic [1:0]             state;
    logic [CW-1:0]          byte_cnt;
    logic [2*WORD_SIZE-1:0] pt;
    logic [2*WORD_SIZE-1:0] block;
    logic                   start;
    logic                   block_valid;
    logic                   error;
    logic                   timed_out;

`ifdef TEA_PACKER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (state == LOAD) begin
            run_cnt <= '0;
        end else if (state == RUN) begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    // Fires on the RUN cycle that completes the limit, so the abort lands exactly TIMEOUT_CYCLES edges in.
    assign timed_out = (state == RUN) && !bus.iDone && (run_cnt == TLAST);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            byte_cnt    <= '0;
            pt          <= '0;
            block       <= '0;
            start       <= 1'b0;
            block_valid <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.iByteValid) begin
                        pt <= {pt[2*WORD_SIZE-9:0], bus.iByte};
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= LOAD;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    start <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (bus.iDone) begin
                        block       <= {bus.iC0, bus.iC1};
                        start       <= 1'b0;
                        block_valid <= 1'b1;
                        state       <= OUT;
                    end else if (timed_out) begin
                        error <= 1'b1;
                        start <= 1'b0;
                        state <= COLLECT;
                    end
                end
                default: begin
                    if (bus.iBlockReady) begin
                        block_valid <= 1'b0;
                        state       <= COLLECT;
                    end
                end
            endcase
        end
    end

    assign bus.oByteReady  = (state == COLLECT);
    assign bus.oV0         = pt[2*WORD_SIZE-1:WORD_SIZE];
    assign bus.oV1         = pt[WORD_SIZE-1:0];
    assign bus.oStart      = start;
    assign bus.oBlock      = block;
    assign bus.oBlockValid = block_valid;
    assign bus.oError      = error;
endmodule

// File: tb/tb_tea_block_packer.sv
// Directed self-checking bench for tea_block_packer with a stub cipher core driven inline.
module tb_tea_block_packer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    tea_block_packer_if #(.WORD_SIZE(16)) bus ();

    tea_block_packer #(
        .WORD_SIZE      (16),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.iByteValid = 1'b1;
        bus.iByte      = b;
        tick();
        bus.iByteValid = 1'b0;
    endtask

    initial begin
        logic [7:0]  bv;
        logic [31:0] exp_pt;
        logic [15:0] c0;
        logic [15:0] c1;
        n_cmp  = 0;
        n_fail = 0;
        rst             = 1'b1;
        bus.iByteValid  = 1'b0;
        bus.iByte       = 8'h00;
        bus.iDone       = 1'b0;
        bus.iC0         = 16'h0000;
        bus.iC1         = 16'h0000;
        bus.iBlockReady = 1'b0;

        // reset for two edges
        tick();
        tick();
        check("rst_ready", bus.oByteReady, 1);
        check("rst_v0", bus.oV0, 0);
        check("rst_v1", bus.oV1, 0);
        check("rst_start", bus.oStart, 0);
        check("rst_block", bus.oBlock, 0);
        check("rst_valid", bus.oBlockValid, 0);
        check("rst_error", bus.oError, 0);
        rst = 1'b0;
        tick();
        check("idle_ready", bus.oByteReady, 1);

        // packing, with iDone / iBlockReady noise outside their states
        bus.iDone       = 1'b1;
        bus.iC0         = 16'hDEAD;
        bus.iC1         = 16'hBEEF;
        bus.iBlockReady = 1'b1;
        send(8'h12);
        send(8'h34);
        check("half_v0", bus.oV0, 16'h0000);
        check("half_v1", bus.oV1, 16'h1234);
        send(8'h56);
        bus.iDone       = 1'b0;
        bus.iBlockReady = 1'b0;
        send(8'h78);
        check("load_start", bus.oStart, 0);
        check("load_ready", bus.oByteReady, 0);
        check("load_v0", bus.oV0, 16'h1234);
        check("load_v1", bus.oV1, 16'h5678);
        check("stray_done_valid", bus.oBlockValid, 0);

        // bytes offered during RUN must not be taken
        bus.iByteValid = 1'b1;
        bus.iByte      = 8'h99;
        tick();
        check("run_start", bus.oStart, 1);
        check("run_ready", bus.oByteReady, 0);
        tick();
        tick();
        check("run_hold_v0", bus.oV0, 16'h1234);
        check("run_hold_v1", bus.oV1, 16'h5678);
        check("run_start2", bus.oStart, 1);
        check("run_valid", bus.oBlockValid, 0);
        bus.iByteValid = 1'b0;

        // capture
        bus.iDone = 1'b1;
        bus.iC0   = 16'hAAAA;
        bus.iC1   = 16'h5555;
        tick();
        bus.iDone = 1'b0;
        bus.iC0   = 16'h0000;
        bus.iC1   = 16'h0000;
        check("cap_block", bus.oBlock, 32'hAAAA5555);
        check("cap_valid", bus.oBlockValid, 1);
        check("cap_start", bus.oStart, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_block", bus.oBlock, 32'hAAAA5555);
            check("stall_valid", bus.oBlockValid, 1);
        end
        bus.iBlockReady = 1'b1;
        tick();
        check("drain_valid", bus.oBlockValid, 0);
        check("drain_ready", bus.oByteReady, 1);

        // back-to-back blocks, valid and ready held high
        bus.iByteValid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            exp_pt = 32'h0;
            for (int k = 0; k < 4; k++) begin
                bv = 8'(8'h40 + 16 * b + k + 1);
                exp_pt = {exp_pt[23:0], bv};
                check("b2b_ready", bus.oByteReady, 1);
                bus.iByte = bv;
                tick();
            end
            check("b2b_load_start", bus.oStart, 0);
            check("b2b_v0", bus.oV0, exp_pt[31:16]);
            check("b2b_v1", bus.oV1, exp_pt[15:0]);
            tick();
            check("b2b_run_start", bus.oStart, 1);
            tick();
            c0 = exp_pt[31:16] ^ 16'hFFFF;
            c1 = exp_pt[15:0] + 16'h0101;
            bus.iDone = 1'b1;
            bus.iC0   = c0;
            bus.iC1   = c1;
            tick();
            bus.iDone = 1'b0;
            check("b2b_block", bus.oBlock, {c0, c1});
            check("b2b_valid", bus.oBlockValid, 1);
            check("b2b_out_start", bus.oStart, 0);
            check("b2b_out_ready", bus.oByteReady, 0);
            tick();
        end
        bus.iByteValid  = 1'b0;
        bus.iBlockReady = 1'b0;

        // reset in the middle of a run
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        tick();
        tick();
        check("mid_run_start", bus.oStart, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_start", bus.oStart, 0);
        check("mid_rst_ready", bus.oByteReady, 1);
        check("mid_rst_v0", bus.oV0, 0);
        check("mid_rst_valid", bus.oBlockValid, 0);

        // a partial block is discarded by reset; byte counter restarts
        send(8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'h21);
        send(8'h22);
        send(8'h23);
        check("partial_ready", bus.oByteReady, 1);
        send(8'h24);
        check("partial_load_ready", bus.oByteReady, 0);
        check("partial_v0", bus.oV0, 16'h2122);
        check("partial_v1", bus.oV1, 16'h2324);
        tick();
        check("partial_run_start", bus.oStart, 1);
        bus.iDone = 1'b1;
        bus.iC0   = 16'h1357;
        bus.iC1   = 16'h2468;
        tick();
        bus.iDone = 1'b0;
        check("partial_block", bus.oBlock, 32'h13572468);
        bus.iBlockReady = 1'b1;
        tick();
        bus.iBlockReady = 1'b0;
        check("partial_drain", bus.oByteReady, 1);

`ifdef TEA_PACKER_TIMEOUT_EN
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        send(8'hC4);
        tick();
        check("to_start", bus.oStart, 1);
        for (int i = 1; i < 20; i++) begin
            tick();
            check("to_wait_start", bus.oStart, 1);
            check("to_wait_error", bus.oError, 0);
        end
        tick();
        check("to_error", bus.oError, 1);
        check("to_start_low", bus.oStart, 0);
        check("to_ready", bus.oByteReady, 1);
        check("to_valid", bus.oBlockValid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_sticky", bus.oError, 1);
            check("to_no_valid", bus.oBlockValid, 0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to_rst_clear", bus.oError, 0);
`else
        check("no_timeout_error", bus.oError, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
